// File: rtl/sma_defs.sv
// -----------------------------------------------------------------------------
// sma_defs
// Shared definitions for the streaming moving-average filter:
//   - legal range of the window-size exponent DEPTH_LOG2
//   - sma_sum_w(): width of the running-sum accumulator
//   - sext(): sign-extension helper
// No ports (package).
// -----------------------------------------------------------------------------
package sma_defs;

   localparam int DEPTH_LOG2_MIN = 1;
   localparam int DEPTH_LOG2_MAX = 8;

   // The sum of 2**depthLog2 samples of dataW bits needs depthLog2 extra bits,
   // so the accumulator can never overflow.
   function automatic int sma_sum_w(input int dataW, input int depthLog2);
      return dataW + depthLog2;
   endfunction

   // Treat bit (width-1) of value as the sign and extend it to 64 bits.
   // Callers truncate the result to the width they need with a size cast.
   function automatic logic signed [63:0] sext(input logic [63:0] value, input int width);
      return $signed(value << (64 - width)) >>> (64 - width);
   endfunction

endpackage

// File: rtl/sma_window_buf.sv
// -----------------------------------------------------------------------------
// sma_window_buf
// Circular buffer of DEPTH = 2**DEPTH_LOG2 samples. The read port always shows
// the slot the next write will overwrite, i.e. the oldest sample once the
// window is full. The read is combinational, so it returns the value from
// before the write in the same cycle.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset (write pointer only)
//   clear    in   synchronous pointer reset
//   wr_en    in   write wr_data and advance the pointer
//   wr_data  in   sample to store
//   rd_data  out  contents of the slot at the write pointer
// -----------------------------------------------------------------------------
module sma_window_buf
   import sma_defs::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_d;

   assign rd_data = mem_q[wr_ptr_q];

   // The pointer is a power-of-two modulus, so it simply wraps.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   // Storage has no reset. Slots are only read into the sum after they have
   // been rewritten since the last reset or clear.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

endmodule

// File: rtl/sma_stream.sv
// -----------------------------------------------------------------------------
// sma_stream
// Streaming boxcar filter. out_data is the mean of the last 2**DEPTH_LOG2
// valid samples. The design keeps a running sum: each new sample is added and
// the sample leaving the window is subtracted. One result is produced per
// accepted sample once the window is full, one cycle after the sample.
// Build option: define SMA_ROUND_EN to round half-up instead of flooring.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   synchronous flush of the window (takes priority over in_valid)
//   in_valid   in   in_data carries a sample this cycle
//   in_data    in   signed sample, DATA_W bits
//   out_valid  out  one-cycle pulse when out_data holds a new average
//   out_data   out  signed average, holds between updates
//   win_full   out  window holds DEPTH samples since the last reset/clear
// -----------------------------------------------------------------------------
module sma_stream
   import sma_defs::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     win_full
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int SUM_W  = sma_sum_w(DATA_W, DEPTH_LOG2);
   localparam int RND_W  = SUM_W + 1;
   localparam int FILL_W = DEPTH_LOG2 + 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

   if (DEPTH_LOG2 < DEPTH_LOG2_MIN || DEPTH_LOG2 > DEPTH_LOG2_MAX) begin : gBadDepth
      $error("sma_stream: DEPTH_LOG2 out of range");
   end

   logic                     accept;
   logic [DATA_W-1:0]        oldestRaw;
   logic signed [SUM_W-1:0]  newSx;
   logic signed [SUM_W-1:0]  oldSx;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  sum_d;
   logic [FILL_W-1:0]        fill_q;
   logic [FILL_W-1:0]        fill_d;
   logic signed [DATA_W-1:0] scaled;
   logic                     win_full_q;
   logic                     out_valid_q;
   logic signed [DATA_W-1:0] out_data_q;

   // A clear drops any sample presented in the same cycle.
   assign accept = in_valid && !clear;

   sma_window_buf #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) uWindowBuf (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .wr_en   (accept),
      .wr_data (in_data),
      .rd_data (oldestRaw)
   );

   // Running-sum update. During warm-up nothing is subtracted, so slots not
   // yet written since reset/clear can never corrupt the sum.
   always_comb begin
      newSx  = SUM_W'(sext(64'(in_data), DATA_W));
      oldSx  = win_full_q ? SUM_W'(sext(64'(oldestRaw), DATA_W)) : '0;
      sum_d  = sum_q;
      fill_d = fill_q;
      if (clear) begin
         sum_d  = '0;
         fill_d = '0;
      end else if (accept) begin
         sum_d = sum_q + newSx - oldSx;
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   // Divide by DEPTH with an arithmetic shift (floor). The rounding variant
   // adds half an LSB first, one bit wider so the add cannot overflow.
`ifdef SMA_ROUND_EN
   logic signed [RND_W-1:0] roundSum;
   always_comb begin
      roundSum = RND_W'(sum_d) + RND_W'(DEPTH / 2);
      scaled   = DATA_W'(roundSum >>> DEPTH_LOG2);
   end
`else
   always_comb begin
      scaled = DATA_W'(sum_d >>> DEPTH_LOG2);
   end
`endif

   // A result is emitted for every accepted sample that leaves the window
   // full. The output holds its last value through gaps and clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q       <= '0;
         fill_q      <= '0;
         win_full_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         win_full_q  <= (fill_d == FILL_FULL);
         out_valid_q <= accept && (fill_d == FILL_FULL);
         if (accept && (fill_d == FILL_FULL)) begin
            out_data_q <= scaled;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign win_full  = win_full_q;

endmodule

// File: tb/tb_sma_stream.sv
// -----------------------------------------------------------------------------
// tb_sma_stream
// Bench for sma_stream. It drives a 4-tap instance through warm-up, sliding,
// negative values, full-scale values, clear and asynchronous reset. It also
// drives an 8-tap instance through a warm-up. A queue-based model of each
// window is checked every cycle, and directed checks use literal values.
// Follows SMA_ROUND_EN if defined.
// -----------------------------------------------------------------------------
module tb_sma_stream;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               clear = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               win_full;

   logic               clear8 = 1'b0;
   logic               in_valid8 = 1'b0;
   logic signed [15:0] in_data8 = '0;
   logic               out_valid8;
   logic signed [15:0] out_data8;
   logic               win_full8;

   int nChecks = 0;
   int nFails  = 0;
   logic compareOn = 1'b0;

   always #5 clk = ~clk;

   sma_stream #(.DATA_W(16), .DEPTH_LOG2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .win_full  (win_full)
   );

   sma_stream #(.DATA_W(16), .DEPTH_LOG2(3)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear8),
      .in_valid  (in_valid8),
      .in_data   (in_data8),
      .out_valid (out_valid8),
      .out_data  (out_data8),
      .win_full  (win_full8)
   );

   // The model computes the mean of the window as an exact integer sum,
   // divided with floor semantics (optionally after adding half a step).
   function automatic int avgOf(input int qs[$], input int depth);
      int s = 0;
      foreach (qs[i]) s += qs[i];
`ifdef SMA_ROUND_EN
      s = s + depth / 2;
`endif
      if (s >= 0) return s / depth;
      return -((-s + depth - 1) / depth);
   endfunction

   // Reference model. It holds the last DEPTH accepted samples in a queue.
   int   q2[$];
   int   q8[$];
   logic ev2 = 1'b0;
   logic ef2 = 1'b0;
   int   ed2 = 0;
   logic ev8 = 1'b0;
   logic ef8 = 1'b0;
   int   ed8 = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q2.delete();
         q8.delete();
         ev2 <= 1'b0; ef2 <= 1'b0; ed2 <= 0;
         ev8 <= 1'b0; ef8 <= 1'b0; ed8 <= 0;
      end else begin
         if (clear) begin
            q2.delete();
            ev2 <= 1'b0;
            ef2 <= 1'b0;
         end else if (in_valid) begin
            q2.push_back(int'(in_data));
            if (q2.size() > 4) void'(q2.pop_front());
            ef2 <= (q2.size() == 4);
            ev2 <= (q2.size() == 4);
            if (q2.size() == 4) ed2 <= avgOf(q2, 4);
         end else begin
            ev2 <= 1'b0;
         end
         if (clear8) begin
            q8.delete();
            ev8 <= 1'b0;
            ef8 <= 1'b0;
         end else if (in_valid8) begin
            q8.push_back(int'(in_data8));
            if (q8.size() > 8) void'(q8.pop_front());
            ef8 <= (q8.size() == 8);
            ev8 <= (q8.size() == 8);
            if (q8.size() == 8) ed8 <= avgOf(q8, 8);
         end else begin
            ev8 <= 1'b0;
         end
      end
   end

   task automatic compareOne(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Compare process. It checks both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (compareOn) begin
         compareOne("model out_valid", int'(out_valid), int'(ev2));
         compareOne("model out_data", int'(out_data), ed2);
         compareOne("model win_full", int'(win_full), int'(ef2));
         compareOne("model8 out_valid", int'(out_valid8), int'(ev8));
         compareOne("model8 out_data", int'(out_data8), ed8);
         compareOne("model8 win_full", int'(win_full8), int'(ef8));
      end
   end

   // Present one cycle of input to the 4-tap instance. Returns just after
   // the edge that consumed it, with valid/clear deasserted.
   task automatic applyStimulus(input logic v, input int d, input logic c);
      in_valid = v;
      in_data  = 16'(d);
      clear    = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic applyStimulus8(input int d);
      in_valid8 = 1'b1;
      in_data8  = 16'(d);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic av, input int ad, input logic af,
                              input logic xv, input int xd, input logic xf);
      compareOne({name, " out_valid"}, int'(av), int'(xv));
      compareOne({name, " out_data"}, ad, xd);
      compareOne({name, " win_full"}, int'(af), int'(xf));
   endtask

   initial begin
      int warm[4];
      warm = '{4, 8, 12, 16};

      #2 rst = 1'b0;
      #10;
      checkOutput("reset", out_valid, int'(out_data), win_full, 1'b0, 0, 1'b0);
      checkOutput("reset8", out_valid8, int'(out_data8), win_full8, 1'b0, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      compareOn = 1'b1;

      // Warm-up: no output until the fourth sample
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, warm[i], 1'b0);
         if (i < 3) checkOutput("warmup", out_valid, int'(out_data), win_full, 1'b0, 0, 1'b0);
      end
      checkOutput("first avg", out_valid, int'(out_data), win_full, 1'b1, 10, 1'b1);

      // Slide, then a gap holds the output
      applyStimulus(1'b1, 20, 1'b0);
      checkOutput("slide", out_valid, int'(out_data), win_full, 1'b1, 14, 1'b1);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("gap", out_valid, int'(out_data), win_full, 1'b0, 14, 1'b1);

      // Negative values and rounding
      applyStimulus(1'b1, -1, 1'b0);
      applyStimulus(1'b1, -1, 1'b0);
      applyStimulus(1'b1, -1, 1'b0);
      applyStimulus(1'b1, -2, 1'b0);
`ifdef SMA_ROUND_EN
      checkOutput("negative", out_valid, int'(out_data), win_full, 1'b1, -1, 1'b1);
`else
      checkOutput("negative", out_valid, int'(out_data), win_full, 1'b1, -2, 1'b1);
`endif

      // Full-scale extremes
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32767, 1'b0);
      checkOutput("max", out_valid, int'(out_data), win_full, 1'b1, 32767, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, -32768, 1'b0);
      checkOutput("min", out_valid, int'(out_data), win_full, 1'b1, -32768, 1'b1);

      // Clear wins over a valid sample; no stale data afterwards
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 10 * i, 1'b0);
      checkOutput("pre-clear", out_valid, int'(out_data), win_full, 1'b1, 45, 1'b1);
      applyStimulus(1'b1, 999, 1'b1);
      checkOutput("clear", out_valid, int'(out_data), win_full, 1'b0, 45, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100, 1'b0);
      checkOutput("post-clear warmup", out_valid, int'(out_data), win_full, 1'b0, 45, 1'b0);
      applyStimulus(1'b1, 100, 1'b0);
      checkOutput("post-clear", out_valid, int'(out_data), win_full, 1'b1, 100, 1'b1);

      // Asynchronous reset between clock edges
      applyStimulus(1'b1, 7, 1'b0);
      applyStimulus(1'b1, 7, 1'b0);
      #2 rst = 1'b0;
      #1;
      checkOutput("async reset", out_valid, int'(out_data), win_full, 1'b0, 0, 1'b0);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8, 1'b0);
      checkOutput("restart warmup", out_valid, int'(out_data), win_full, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 8, 1'b0);
      checkOutput("restart", out_valid, int'(out_data), win_full, 1'b1, 8, 1'b1);

      // 8-tap warm-up on the second instance
      for (int i = 0; i < 8; i++) begin
         applyStimulus8(i);
         if (i < 7) checkOutput("warmup8", out_valid8, int'(out_data8), win_full8, 1'b0, 0, 1'b0);
      end
`ifdef SMA_ROUND_EN
      checkOutput("first avg8", out_valid8, int'(out_data8), win_full8, 1'b1, 4, 1'b1);
`else
      checkOutput("first avg8", out_valid8, int'(out_data8), win_full8, 1'b1, 3, 1'b1);
`endif

      repeat (2) @(posedge clk);
      #1;
      compareOn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
